// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: round-robin arbiter sharing one vector memory bus between pipeline stages
// (0 = fetch, 1 = execute, 2 = store). It keeps one request in flight at a time. Reads stay
// outstanding until memory answers or the watchdog expires. Writes are posted.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid/ready       per-requester handshake (req_ready is combinational, one-hot or zero)
//   req_write/addr/       packed per-requester payload, requester i at [i*W +: W]
//     data/id
//   rsp_valid/data/err    one-cycle read response strobe routed to the owner; err = watchdog
//   mem_req_*             registered copy of the granted request, held until mem_req_ready
//   mem_rsp_valid/data    read response from memory (ignored unless a read is outstanding)
//   timeout_err           sticky watchdog flag
//   grant_owner           index of the current or last owner
module vec_mem_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 256,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned ID_W    = 8,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic                      mem_req_write,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [DATA_W-1:0]         mem_req_data,
    output logic [ID_W-1:0]           mem_req_id,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_W-1:0]         mem_rsp_data,
    output logic                      timeout_err,
    output logic [OWN_W-1:0]          grant_owner
);

    // Watchdog is wide enough to hold TIMEOUT itself; 1 bit when the watchdog is disabled.
    localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    state_e              state_q, state_d;
    logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [OWN_W-1:0]    grant_owner_q, grant_owner_d;
    logic                mem_req_write_q, mem_req_write_d;
    logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
    logic [DATA_W-1:0]   mem_req_data_q, mem_req_data_d;
    logic [ID_W-1:0]     mem_req_id_q, mem_req_id_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                timeout_err_q, timeout_err_d;

    logic                sel_found;
    logic [OWN_W-1:0]    sel_idx;
    int unsigned         scan_idx;

    // Round-robin pick: first valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            scan_idx = 32'(rr_ptr_q) + off;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!sel_found && req_valid[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = OWN_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_owner_d   = grant_owner_q;
        mem_req_write_d = mem_req_write_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_data_d  = mem_req_data_q;
        mem_req_id_d    = mem_req_id_q;
        wd_d            = wd_q;
        rsp_valid_d     = '0;
        rsp_data_d      = rsp_data_q;
        rsp_err_d       = 1'b0;
        timeout_err_d   = timeout_err_q;
        req_ready       = '0;

        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    mem_req_write_d    = req_write[sel_idx];
                    mem_req_addr_d     = req_addr[sel_idx*ADDR_W +: ADDR_W];
                    mem_req_data_d     = req_data[sel_idx*DATA_W +: DATA_W];
                    mem_req_id_d       = req_id[sel_idx*ID_W +: ID_W];
                    grant_owner_d      = sel_idx;
                    rr_ptr_d           = (sel_idx == OWN_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                    state_d            = StIssue;
                end
            end
            StIssue: begin
                if (mem_req_ready) begin
                    if (mem_req_write_q) begin
                        state_d = StIdle;
                    end else begin
                        wd_d    = '0;
                        state_d = StWaitRsp;
                    end
                end
            end
            StWaitRsp: begin
                if (mem_rsp_valid) begin
                    rsp_valid_d[grant_owner_q] = 1'b1;
                    rsp_data_d                 = mem_rsp_data;
                    state_d                    = StIdle;
                end else if ((TIMEOUT != 0) && (wd_q == WD_LAST)) begin
                    // This cycle's increment reaches TIMEOUT: answer on the owner's behalf.
                    wd_d                       = wd_q + 1'b1;
                    rsp_valid_d[grant_owner_q] = 1'b1;
                    rsp_err_d                  = 1'b1;
                    rsp_data_d                 = '0;
                    timeout_err_d              = 1'b1;
                    state_d                    = StIdle;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            grant_owner_q   <= '0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_data_q  <= '0;
            mem_req_id_q    <= '0;
            wd_q            <= '0;
            rsp_valid_q     <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_owner_q   <= grant_owner_d;
            mem_req_write_q <= mem_req_write_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_data_q  <= mem_req_data_d;
            mem_req_id_q    <= mem_req_id_d;
            wd_q            <= wd_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    // Decoded from the state flop so a reset mid-issue drops the request immediately.
    assign mem_req_valid = (state_q == StIssue);
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_data  = mem_req_data_q;
    assign mem_req_id    = mem_req_id_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign timeout_err   = timeout_err_q;
    assign grant_owner   = grant_owner_q;

endmodule

// File: doc/vec_mem_arbiter.md
# vec_mem_arbiter

Round-robin arbiter that shares the single vector memory bus between the core's pipeline stages (fetch, execute/operand fetch, store). Each stage presents a request on its own port. The arbiter grants one at a time and drives the memory bus. It keeps one read outstanding, routes the read response back to its owner, and flags lost responses with a watchdog. It sits between the pipeline stages and the core's memory port.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (index 0 = fetch, 1 = execute, 2 = store)
- ADDR_W, 256, packed vector address width per request
- DATA_W, 256, packed vector data width
- ID_W, 8, bus ID width
- TIMEOUT, 1024, read watchdog limit in cycles (0 disables)

Ports:
- clk  in  1  clock; one clock domain
- reset_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  request pending, per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_write  in  NUM_REQ  1 = write (posted), 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_REQ*DATA_W  write data, same packing
- req_id  in  NUM_REQ*ID_W  bus ID, same packing
- rsp_valid  out  NUM_REQ  read response strobe, one-hot, one cycle
- rsp_data  out  DATA_W  read response data, shared by all requesters
- rsp_err  out  1  qualifies rsp_valid; 1 = response produced by watchdog
- mem_req_valid  out  1  request to memory bus
- mem_req_ready  in  1  memory bus accepts
- mem_req_write, mem_req_addr, mem_req_data, mem_req_id  out  1/ADDR_W/DATA_W/ID_W  registered copy of granted request
- mem_rsp_valid  in  1  read response from memory
- mem_rsp_data  in  DATA_W  read response data
- timeout_err  out  1  sticky watchdog flag, cleared only by reset
- grant_owner  out  $clog2(NUM_REQ)  index of current or last owner

## Operation
- States: IDLE, ISSUE, WAIT_RSP.
- Reset (asynchronous) values:
  - state = IDLE, rr_ptr = 0, grant_owner = 0, watchdog = 0.
  - Outputs req_ready, rsp_valid, rsp_err, mem_req_valid, timeout_err all 0.
  - mem_req_* and rsp_data all 0.
- IDLE:
  - Select the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready[i] = 1 combinationally in the same cycle, so the handshake is req_valid & req_ready.
  - Capture write/addr/data/id into mem_req_* and set grant_owner = i.
  - Set rr_ptr = (i+1) mod NUM_REQ and go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - mem_req_valid = 1, with payload held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready: a write goes to IDLE (posted, no response); a read clears the watchdog and goes to WAIT_RSP.
- WAIT_RSP:
  - mem_rsp_valid: next cycle rsp_valid[grant_owner] = 1, rsp_data = mem_rsp_data, rsp_err = 0; state goes to IDLE.
  - Otherwise the watchdog increments. When it reaches TIMEOUT (TIMEOUT≠0): next cycle rsp_valid[owner] = 1, rsp_err = 1, rsp_data = 0, timeout_err = 1; state goes to IDLE.
- mem_rsp_valid outside WAIT_RSP is ignored and dropped.
- req_ready is 0 in ISSUE and WAIT_RSP: requesters hold req_valid and their payload until accepted.
- Watchdog width is $clog2(TIMEOUT+1) and saturates; it never wraps.

## Timing
- Grant to bus: request accepted in cycle N → mem_req_valid in cycle N+1.
- Read loop: mem_rsp_valid in cycle M → rsp_valid in cycle M+1.
- Back-to-back service: the next grant can occur in the same cycle rsp_valid is driven (IDLE re-entered); for writes, in the cycle after mem_req_ready.
- Minimum per-read occupancy is 3 cycles plus memory latency; per-write is 2 cycles plus bus stall.
- rr_ptr updates only on a grant. A requester that keeps req_valid high is guaranteed service within NUM_REQ grants.
- Reset mid-transaction (ISSUE or WAIT_RSP) abandons it: mem_req_valid drops immediately and no rsp_valid is produced.

## Test plan
- Single read from store (req 2), memory answers 5 cycles after acceptance with 0xDEAD… → mem_req_valid one cycle after grant; rsp_valid = 3'b100, rsp_data = 0xDEAD…, rsp_err = 0.
- All three requesters hold reads continuously from reset → grant order 0,1,2,0,1,2; each rsp_valid routed to the matching owner.
- Write from req 1 with mem_req_ready low for 4 cycles → payload stable throughout, no rsp_valid, next grant goes to req 2 the cycle after acceptance.
- TIMEOUT=16, memory never answers → exactly 16 cycles in WAIT_RSP, then rsp_valid[owner] = 1 with rsp_err = 1; timeout_err stays 1 until reset.
- Stray mem_rsp_valid pulse in IDLE → no rsp_valid; a following read still completes normally.
- reset_n low while in WAIT_RSP → all outputs 0 asynchronously, rr_ptr = 0; after release, req 0 is granted first.
